fadd_norm: RTL and testbench

- Normalize/round stage of the 16-bit (IEEE half) floating-point adder; sits directly downstream of the fraction add/subtract stage.
- Consumes the 15-bit raw sum/difference plus the large operand's sign and exponent, and produces the packed fp16 result.
- Two-stage pipeline with valid/ready handshaking:
  - S1: leading-zero count and normalizing shift.
  - S2: round-to-nearest-even, exponent adjust, overflow handling.

---
 rtl/fp16_pkg.sv | 35 +++
 rtl/fadd_lzc.sv | 18 +
 rtl/fadd_norm.sv | 155 +++++++++++++++
 tb/tb_fadd_norm.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared fp16 format constants and types for the floating-point adder stages
// (align, add, normalize/round).
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;
  localparam int GRS_W  = 3;
  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  // Normalized beat held between S1 and S2. The hidden bit is dropped because
  // the exponent already encodes it; exp keeps one extra bit to expose overflow.
  typedef struct packed {
    logic                    sign;
    logic [EXP_W:0]          exp;
    logic [FRAC_W+GRS_W-1:0] mant;
    logic                    special;
    logic [15:0]             special_val;
  } norm_beat_t;

  function automatic fp16_t fp16_inf(input logic sign);
    fp16_t r;
    r.sign = sign;
    r.exp  = EXP_MAX;
    r.frac = '0;
    return r;
  endfunction

endpackage

// File: rtl/fadd_lzc.sv
// Leading-zero counter over a 14-bit mantissa (bit 13 = hidden position).
// Purely combinational; an all-zero input reports 14.
module fadd_lzc (
  input  logic [13:0] data_i,
  output logic [3:0]  count_o
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    count_o = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (data_i[i]) begin
        count_o = 4'(13 - i);
      end
    end
  end

endmodule

// File: rtl/fadd_norm.sv
// fp16 adder normalize/round stage: S1 normalizes the raw sum, S2 rounds (RNE)
// and packs. Optional macro FADD_NORM_FLAGS_EN adds out_flags {ovf, unf, inexact}.
module fadd_norm
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [4:0]  in_exp,
  input  logic [14:0] in_cal_frac,
  input  logic        in_special,
  input  logic [15:0] in_special_val,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef FADD_NORM_FLAGS_EN
  output logic [2:0]  out_flags,
  output logic [15:0] out_result
`else
  output logic [15:0] out_result
`endif
);

  norm_beat_t  s1_q;
  norm_beat_t  s1_d;
  logic        s1_valid_q;
  logic        out_valid_q;
  logic [15:0] out_result_q;
  logic [15:0] result_d;
  logic        adv1;
  logic        adv2;

  assign adv2       = !out_valid_q || out_ready;
  assign adv1       = !s1_valid_q || adv2;
  assign in_ready   = adv1;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

  // ---------------- S1: leading-zero count and normalizing shift ----------------
  logic [3:0]     lz;
  logic [3:0]     dn_shift;
  logic [EXP_W:0] exp_ext;

  fadd_lzc u_lzc (
    .data_i  (in_cal_frac[13:0]),
    .count_o (lz)
  );

  always_comb begin
    exp_ext          = {1'b0, in_exp};
    dn_shift         = (in_exp == '0) ? 4'd0 : (in_exp[3:0] - 4'd1);
    s1_d             = '0;
    s1_d.sign        = in_sign;
    s1_d.special     = in_special;
    s1_d.special_val = in_special_val;
    if (in_cal_frac[14]) begin
      // Carry out: shift right one, folding both dropped low bits into sticky.
      s1_d.mant = {in_cal_frac[13:3], in_cal_frac[2], |in_cal_frac[1:0]};
      s1_d.exp  = exp_ext + 6'd1;
    end else if (in_cal_frac[13]) begin
      // Two denormals can sum into the normal range; that is exponent field 1.
      s1_d.mant = in_cal_frac[12:0];
      s1_d.exp  = (in_exp == '0) ? 6'd1 : exp_ext;
    end else if (in_cal_frac == '0) begin
      s1_d.sign = 1'b0;
      s1_d.exp  = '0;
      s1_d.mant = '0;
    end else if (exp_ext > {2'b00, lz}) begin
      s1_d.mant = in_cal_frac[12:0] << lz;
      s1_d.exp  = exp_ext - {2'b00, lz};
    end else begin
      // Cannot reach the hidden bit: stop at the denormal scale (2^-14).
      s1_d.mant = in_cal_frac[12:0] << dn_shift;
      s1_d.exp  = '0;
    end
  end

  // ---------------- S2: round to nearest even, overflow to Inf ----------------
  logic                    guard_b;
  logic                    round_b;
  logic                    sticky_b;
  logic                    inc;
  logic                    ovf;
  logic [EXP_W+FRAC_W-1:0] rounded;

  always_comb begin
    guard_b  = s1_q.mant[2];
    round_b  = s1_q.mant[1];
    sticky_b = s1_q.mant[0];
    inc      = guard_b & (round_b | sticky_b | s1_q.mant[GRS_W]);
    // Incrementing {exp, frac} as one number carries mantissa overflow into
    // the exponent and promotes a full denormal to exponent 1.
    rounded  = {s1_q.exp[EXP_W-1:0], s1_q.mant[FRAC_W+GRS_W-1:GRS_W]} + 15'(inc);
    ovf      = (s1_q.exp >= {1'b0, EXP_MAX}) || (rounded[14:10] == EXP_MAX);
    if (s1_q.special) begin
      result_d = s1_q.special_val;
    end else if (ovf) begin
      result_d = fp16_inf(s1_q.sign);
    end else begin
      result_d = {s1_q.sign, rounded};
    end
  end

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= 16'h0000;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
      end
      if (adv2) begin
        out_valid_q <= s1_valid_q;
      end
      if (adv2 && s1_valid_q) begin
        out_result_q <= result_d;
      end
    end
  end

  // Data path needs no reset: it is only observed behind the valid bits.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_q <= s1_d;
    end
  end

`ifdef FADD_NORM_FLAGS_EN
  logic [2:0] flags_d;
  logic [2:0] out_flags_q;
  logic       inexact;

  always_comb begin
    inexact = guard_b | round_b | sticky_b;
    flags_d = 3'b000;
    if (!s1_q.special) begin
      flags_d = {ovf, (result_d[14:10] == '0) && inexact, inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags_q <= 3'b000;
    end else if (adv2 && s1_valid_q) begin
      out_flags_q <= flags_d;
    end
  end

  assign out_flags = out_flags_q;
`endif

endmodule

// File: tb/tb_fadd_norm.sv
// Scoreboard bench for fadd_norm: expected results are queued at input
// acceptance and compared in order as the DUT hands results downstream.
`timescale 1ns/1ps
module tb_fadd_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [14:0] in_cal_frac;
  logic        in_special;
  logic [15:0] in_special_val;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
`ifdef FADD_NORM_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  always #5 clk = ~clk;

  fadd_norm dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_cal_frac    (in_cal_frac),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
`ifdef FADD_NORM_FLAGS_EN
    .out_flags      (out_flags),
`endif
    .out_result     (out_result)
  );

  typedef struct {
    logic        sign;
    logic [4:0]  exp;
    logic [14:0] frac;
    logic        special;
    logic [15:0] sval;
    logic [15:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  flags;
    int          id;
  } sb_t;

  vec_t stim[$];
  sb_t  sb[$];
  int   nxt;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [2:0] cur_flags();
`ifdef FADD_NORM_FLAGS_EN
    return out_flags;
`else
    return 3'b000;
`endif
  endfunction

  task automatic add_vec(input logic s, input logic [4:0] e, input logic [14:0] f,
                         input logic sp, input logic [15:0] sv,
                         input logic [15:0] r, input logic [2:0] fl);
    vec_t v;
    v.sign = s; v.exp = e; v.frac = f; v.special = sp; v.sval = sv;
    v.res = r; v.flags = fl;
    stim.push_back(v);
  endtask

  task automatic load_all();
    stim.delete();
    add_vec(0, 15, 15'h4000, 0, 16'h0, 16'h4000, 3'b000); // 1.0 + 1.0
    add_vec(0, 15, 15'h0000, 0, 16'h0, 16'h0000, 3'b000); // exact cancel
    add_vec(1, 15, 15'h0000, 0, 16'h0, 16'h0000, 3'b000); // cancel gives +0
    add_vec(0, 15, 15'h2004, 0, 16'h0, 16'h3C00, 3'b001); // tie, even lsb
    add_vec(0, 15, 15'h200C, 0, 16'h0, 16'h3C02, 3'b001); // tie, odd lsb
    add_vec(0, 30, 15'h7FF8, 0, 16'h0, 16'h7C00, 3'b101); // overflow
    add_vec(0,  1, 15'h1000, 0, 16'h0, 16'h0200, 3'b000); // denormal
    add_vec(1, 15, 15'h2000, 0, 16'h0, 16'hBC00, 3'b000); // -1.0
    add_vec(0, 15, 15'h0800, 0, 16'h0, 16'h3400, 3'b000); // left shift 2
    add_vec(0,  0, 15'h0008, 0, 16'h0, 16'h0001, 3'b000); // smallest denormal
    add_vec(0, 15, 15'h3FFC, 0, 16'h0, 16'h4000, 3'b001); // round carries to exp
    add_vec(0, 30, 15'h3FFC, 0, 16'h0, 16'h7C00, 3'b101); // round to Inf
    add_vec(0, 30, 15'h4000, 0, 16'h0, 16'h7C00, 3'b100); // exact overflow
    add_vec(0,  1, 15'h1004, 0, 16'h0, 16'h0200, 3'b011); // underflow inexact
    add_vec(0, 15, 15'h4018, 0, 16'h0, 16'h4002, 3'b001); // tie after right shift
    add_vec(0, 15, 15'h4005, 0, 16'h0, 16'h4000, 3'b001); // sticky after right shift
    add_vec(0, 30, 15'h7FF8, 1, 16'h7E00, 16'h7E00, 3'b000); // special NaN
    add_vec(1,  3, 15'h0123, 1, 16'hFC00, 16'hFC00, 3'b000); // special -Inf
    add_vec(0, 20, 15'h0FFF, 0, 16'h0, 16'h4C00, 3'b001); // shift then carry
    add_vec(0,  3, 15'h0100, 0, 16'h0, 16'h0080, 3'b000); // partial denormal shift
  endtask

  task automatic drive_next();
    if (nxt < stim.size()) begin
      in_valid       = 1'b1;
      in_sign        = stim[nxt].sign;
      in_exp         = stim[nxt].exp;
      in_cal_frac    = stim[nxt].frac;
      in_special     = stim[nxt].special;
      in_special_val = stim[nxt].sval;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Samples one cycle at the falling edge and records any accepted beat.
  task automatic observe(output bit fire, output bit ov, output logic [15:0] res,
                         output logic [2:0] flg, output int occ,
                         output logic rdy, output logic ordy);
    sb_t e;
    @(negedge clk);
    ov   = out_valid;
    ordy = out_ready;
    fire = out_valid && out_ready;
    res  = out_result;
    flg  = cur_flags();
    occ  = sb.size();
    rdy  = in_ready;
    if (in_valid && in_ready) begin
      e.res = stim[nxt].res; e.flags = stim[nxt].flags; e.id = nxt;
      sb.push_back(e);
      nxt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 0; in_exp = 0; in_cal_frac = 0; in_special = 0; in_special_val = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: out_valid=%b want 0", out_valid); end
    checks++; if (out_result !== 16'h0000) begin errors++; $display("FAIL reset_result: out_result=%h want 0000", out_result); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: in_ready=%b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: out_valid=%b want 0", out_valid); end
    $display("test_reset done");
  endtask

  task automatic test_latency();
    bit fire, ov; logic [15:0] res; logic [2:0] flg; int occ; logic rdy, ordy;
    sb_t e;
    stim.delete(); sb.delete();
    add_vec(0, 15, 15'h4000, 0, 16'h0, 16'h4000, 3'b000);
    nxt = 0;
    @(posedge clk); #1; out_ready = 1'b1; drive_next();
    observe(fire, ov, res, flg, occ, rdy, ordy);
    @(posedge clk); #1; drive_next();
    observe(fire, ov, res, flg, occ, rdy, ordy);
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL latency_early: out_valid=%b want 0 one cycle after input", ov); end
    @(posedge clk); #1;
    observe(fire, ov, res, flg, occ, rdy, ordy);
    checks++; if (ov !== 1'b1 || res !== 16'h4000) begin errors++; $display("FAIL latency_2cyc: out_valid=%b result=%h want 1/4000", ov, res); end
    if (fire && sb.size() != 0) e = sb.pop_front();
    @(posedge clk); #1;
    $display("test_latency: result=%h", res);
  endtask

  task automatic test_vectors();
    bit fire, ov; logic [15:0] res; logic [2:0] flg; int occ; logic rdy, ordy;
    int cyc; sb_t e;
    load_all(); sb.delete(); nxt = 0; cyc = 0;
    out_ready = 1'b1; drive_next();
    while ((nxt < stim.size() || sb.size() != 0) && cyc < 200) begin
      observe(fire, ov, res, flg, occ, rdy, ordy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL vec_in_ready: in_ready=%b want 1", rdy); end
      if (fire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL vec_extra: unexpected result=%h", res);
        end else begin
          e = sb.pop_front();
          if (res !== e.res) begin errors++; $display("FAIL vec_result[%0d]: got=%h want=%h", e.id, res, e.res); end
`ifdef FADD_NORM_FLAGS_EN
          checks++;
          if (flg !== e.flags) begin errors++; $display("FAIL vec_flags[%0d]: got=%b want=%b", e.id, flg, e.flags); end
`endif
          $display("vec %0d: result=%h flags=%b", e.id, res, flg);
        end
      end
      @(posedge clk); #1; drive_next(); cyc++;
    end
    checks++; if (nxt < stim.size() || sb.size() != 0) begin errors++; $display("FAIL vec_timeout: sent=%0d pending=%0d want all drained", nxt, sb.size()); end
  endtask

  task automatic test_backpressure();
    bit fire, ov; logic [15:0] res; logic [2:0] flg; int occ; logic rdy, ordy;
    logic held; logic [15:0] held_res; int stalls, cyc; bit saw_full; sb_t e;
    stim.delete(); sb.delete();
    add_vec(0, 15, 15'h4000, 0, 16'h0, 16'h4000, 3'b000);
    add_vec(0, 15, 15'h200C, 0, 16'h0, 16'h3C02, 3'b001);
    add_vec(1, 15, 15'h2000, 0, 16'h0, 16'hBC00, 3'b000);
    add_vec(0,  1, 15'h1000, 0, 16'h0, 16'h0200, 3'b000);
    nxt = 0; held = 0; held_res = '0; stalls = 0; cyc = 0; saw_full = 0;
    out_ready = 1'b0; drive_next();
    while ((nxt < stim.size() || sb.size() != 0) && cyc < 100) begin
      observe(fire, ov, res, flg, occ, rdy, ordy);
      checks++; if (rdy !== ((occ < 2) || ordy)) begin errors++; $display("FAIL bp_in_ready: in_ready=%b occupancy=%0d out_ready=%b", rdy, occ, ordy); end
      if (!rdy) saw_full = 1;
      if (held) begin
        checks++; if (ov !== 1'b1 || res !== held_res) begin errors++; $display("FAIL bp_stable: valid=%b result=%h want 1/%h", ov, res, held_res); end
      end
      held = ov && !ordy; held_res = res;
      if (ov && !ordy) stalls++;
      if (fire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_extra: unexpected result=%h", res);
        end else begin
          e = sb.pop_front();
          if (res !== e.res) begin errors++; $display("FAIL bp_result[%0d]: got=%h want=%h", e.id, res, e.res); end
          $display("bp %0d: result=%h", e.id, res);
        end
      end
      @(posedge clk); #1; out_ready = (stalls >= 3); drive_next(); cyc++;
    end
    checks++; if (nxt < stim.size() || sb.size() != 0) begin errors++; $display("FAIL bp_timeout: sent=%0d pending=%0d", nxt, sb.size()); end
    checks++; if (!saw_full) begin errors++; $display("FAIL bp_full: in_ready=1 throughout, want 0 when both stages full"); end
  endtask

  task automatic test_back_to_back();
    bit fire, ov; logic [15:0] res; logic [2:0] flg; int occ; logic rdy, ordy;
    logic held; logic [15:0] held_res; int cyc; sb_t e;
    load_all(); sb.delete(); nxt = 0; cyc = 0; held = 0; held_res = '0;
    out_ready = 1'b1; drive_next();
    while ((nxt < stim.size() || sb.size() != 0) && cyc < 400) begin
      observe(fire, ov, res, flg, occ, rdy, ordy);
      checks++; if (rdy !== ((occ < 2) || ordy)) begin errors++; $display("FAIL b2b_in_ready: in_ready=%b occupancy=%0d out_ready=%b", rdy, occ, ordy); end
      if (held) begin
        checks++; if (ov !== 1'b1 || res !== held_res) begin errors++; $display("FAIL b2b_stable: valid=%b result=%h want 1/%h", ov, res, held_res); end
      end
      held = ov && !ordy; held_res = res;
      if (fire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_extra: unexpected result=%h", res);
        end else begin
          e = sb.pop_front();
          if (res !== e.res) begin errors++; $display("FAIL b2b_result[%0d]: got=%h want=%h", e.id, res, e.res); end
`ifdef FADD_NORM_FLAGS_EN
          checks++;
          if (flg !== e.flags) begin errors++; $display("FAIL b2b_flags[%0d]: got=%b want=%b", e.id, flg, e.flags); end
`endif
          $display("b2b %0d: result=%h", e.id, res);
        end
      end
      @(posedge clk); #1; out_ready = ($urandom_range(0, 2) != 0); drive_next(); cyc++;
    end
    checks++; if (nxt < stim.size() || sb.size() != 0) begin errors++; $display("FAIL b2b_timeout: sent=%0d pending=%0d", nxt, sb.size()); end
  endtask

  task automatic test_reset_flight();
    bit fire, ov; logic [15:0] res; logic [2:0] flg; int occ; logic rdy, ordy;
    stim.delete(); sb.delete();
    add_vec(0, 15, 15'h4000, 0, 16'h0, 16'h4000, 3'b000);
    add_vec(0, 15, 15'h200C, 0, 16'h0, 16'h3C02, 3'b001);
    nxt = 0;
    @(posedge clk); #1; out_ready = 1'b0; drive_next();
    observe(fire, ov, res, flg, occ, rdy, ordy);
    @(posedge clk); #1; drive_next();
    observe(fire, ov, res, flg, occ, rdy, ordy);
    @(posedge clk); #1; drive_next();
    observe(fire, ov, res, flg, occ, rdy, ordy);
    checks++; if (ov !== 1'b1 || res !== 16'h4000) begin errors++; $display("FAIL rstf_loaded: valid=%b result=%h want 1/4000", ov, res); end
    @(posedge clk); #1; rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstf_valid: out_valid=%b want 0", out_valid); end
    checks++; if (out_result !== 16'h0000) begin errors++; $display("FAIL rstf_result: out_result=%h want 0000", out_result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstf_in_ready: in_ready=%b want 1", in_ready); end
    sb.delete();
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstf_ghost: out_valid=%b want 0 after flush", out_valid); end
    $display("test_reset_flight done");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
